// File: rtl/cmplx_twiddle_seq_if.sv
// Bundle of the upstream, multiplier and downstream handshakes of the twiddle sequencer.
// slave is the sequencer side; master is the environment side (buffer, multiplier, butterfly).
interface cmplx_twiddle_seq_if #(
    parameter int unsigned N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic           conj;
    logic [N-1:0]   xr;
    logic [N-1:0]   xi;
    logic [N-1:0]   wr;
    logic [N-1:0]   wi;
    logic           mul_ld;
    logic [N-1:0]   mul_m;
    logic [N-1:0]   mul_r;
    logic           mul_valid;
    logic [2*N-1:0] mul_p;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   yr;
    logic [N-1:0]   yi;

    modport slave (
        input  in_valid, conj, xr, xi, wr, wi, mul_valid, mul_p, out_ready,
        output in_ready, mul_ld, mul_m, mul_r, out_valid, yr, yi
    );

    modport master (
        output in_valid, conj, xr, xi, wr, wi, mul_valid, mul_p, out_ready,
        input  in_ready, mul_ld, mul_m, mul_r, out_valid, yr, yi
    );
endinterface

// File: rtl/cmplx_twiddle_seq.sv
// Complex twiddle multiply Y = X*W (or X*conj(W)) built from four serial real products
// on an external Booth multiplier, with round-half-up and saturation to Q1.(N-1).
module cmplx_twiddle_seq #(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 2*N+2
) (
    input logic                clk,
    input logic                rst,
    cmplx_twiddle_seq_if.slave bus
);

    localparam int unsigned PW = 2*N;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [AW-1:0] RND     = {{(AW-N+1){1'b0}}, 1'b1, {(N-2){1'b0}}};
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [1:0]           k_q, k_d;
    logic                 conj_q, conj_d;
    logic [N-1:0]         xr_q, xr_d, xi_q, xi_d, wr_q, wr_d, wi_q, wi_d;
    logic signed [AW-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
    logic                 in_ready_q, in_ready_d;
    logic                 mul_ld_q, mul_ld_d;
    logic [N-1:0]         mul_m_q, mul_m_d, mul_r_q, mul_r_d;
    logic                 out_valid_q, out_valid_d;
    logic [N-1:0]         yr_q, yr_d, yi_q, yi_d;
    logic signed [AW-1:0] p_ext;

    // Q2.(2N-2) sum -> Q1.(N-1): add half an LSB, drop N-1 bits, clamp to N-bit range.
    function automatic logic [N-1:0] round_sat(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] t;
        t = (a + RND) >>> (N-1);
        if (t > SAT_MAX) begin
            round_sat = SAT_MAX[N-1:0];
        end else if (t < SAT_MIN) begin
            round_sat = SAT_MIN[N-1:0];
        end else begin
            round_sat = t[N-1:0];
        end
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        conj_d  = conj_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        wr_d    = wr_q;
        wi_d    = wi_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        mul_m_d = mul_m_q;
        mul_r_d = mul_r_q;
        yr_d    = yr_q;
        yi_d    = yi_q;
        p_ext   = {{(AW-PW){bus.mul_p[PW-1]}}, bus.mul_p};

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    xr_d    = bus.xr;
                    xi_d    = bus.xi;
                    wr_d    = bus.wr;
                    wi_d    = bus.wi;
                    conj_d  = bus.conj;
                    acc_r_d = '0;
                    acc_i_d = '0;
                    k_d     = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mul_valid) begin
                    // Conjugation only flips the sign of the Wi terms at accumulate time.
                    case (k_q)
                        2'd0:    acc_r_d = acc_r_q + p_ext;
                        2'd1:    acc_r_d = conj_q ? acc_r_q + p_ext : acc_r_q - p_ext;
                        2'd2:    acc_i_d = conj_q ? acc_i_q - p_ext : acc_i_q + p_ext;
                        default: acc_i_d = acc_i_q + p_ext;
                    endcase
                    if (k_q == 2'd3) begin
                        yr_d    = round_sat(acc_r_d);
                        yi_d    = round_sat(acc_i_d);
                        state_d = S_OUT;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Operand pair for the product about to be issued; held until the next issue.
        if (state_d == S_ISSUE) begin
            case (k_d)
                2'd0:    begin mul_m_d = xr_d; mul_r_d = wr_d; end
                2'd1:    begin mul_m_d = xi_d; mul_r_d = wi_d; end
                2'd2:    begin mul_m_d = xr_d; mul_r_d = wi_d; end
                default: begin mul_m_d = xi_d; mul_r_d = wr_d; end
            endcase
        end

        in_ready_d  = (state_d == S_IDLE);
        mul_ld_d    = (state_d == S_ISSUE);
        out_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            conj_q      <= 1'b0;
            xr_q        <= '0;
            xi_q        <= '0;
            wr_q        <= '0;
            wi_q        <= '0;
            acc_r_q     <= '0;
            acc_i_q     <= '0;
            in_ready_q  <= 1'b0;
            mul_ld_q    <= 1'b0;
            mul_m_q     <= '0;
            mul_r_q     <= '0;
            out_valid_q <= 1'b0;
            yr_q        <= '0;
            yi_q        <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            conj_q      <= conj_d;
            xr_q        <= xr_d;
            xi_q        <= xi_d;
            wr_q        <= wr_d;
            wi_q        <= wi_d;
            acc_r_q     <= acc_r_d;
            acc_i_q     <= acc_i_d;
            in_ready_q  <= in_ready_d;
            mul_ld_q    <= mul_ld_d;
            mul_m_q     <= mul_m_d;
            mul_r_q     <= mul_r_d;
            out_valid_q <= out_valid_d;
            yr_q        <= yr_d;
            yi_q        <= yi_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mul_ld    = mul_ld_q;
    assign bus.mul_m     = mul_m_q;
    assign bus.mul_r     = mul_r_q;
    assign bus.out_valid = out_valid_q;
    assign bus.yr        = yr_q;
    assign bus.yi        = yi_q;

endmodule

// File: tb/tb_cmplx_twiddle_seq.sv
// Bench for cmplx_twiddle_seq: exact-product multiplier model (L=9), scoreboard of expected Y.
module tb_cmplx_twiddle_seq;

    localparam int unsigned N = 16;
    localparam int          L = 9;

    typedef struct packed {
        logic [N-1:0] yr;
        logic [N-1:0] yi;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    cmplx_twiddle_seq_if #(.N(N)) dif ();

    cmplx_twiddle_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: Valid high L cycles after the Ld cycle, exact signed product.
    logic           m_valid;
    logic [2*N-1:0] m_p;
    int             m_cnt;
    logic           spur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_p     <= '0;
        end else begin
            m_valid <= 1'b0;
            if (dif.mul_ld) begin
                m_cnt <= L - 1;
                m_p   <= 32'($signed(dif.mul_m) * $signed(dif.mul_r));
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) m_valid <= 1'b1;
            end
        end
    end

    assign dif.mul_valid = m_valid | spur;
    assign dif.mul_p     = spur ? 32'hDEAD_BEEF : m_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_cvt(input longint v);
        longint t;
        t = (v + 64'sd16384) >>> 15;
        if (t > 64'sd32767) t = 64'sd32767;
        else if (t < -64'sd32768) t = -64'sd32768;
        return 16'(t);
    endfunction

    function automatic exp_t ref_y(input logic [N-1:0] a, b, c, d, input logic cj);
        longint xr, xi, wr, wi, re, im;
        exp_t   r;
        xr = longint'($signed(a));
        xi = longint'($signed(b));
        wr = longint'($signed(c));
        wi = longint'($signed(d));
        re = cj ? xr*wr + xi*wi : xr*wr - xi*wi;
        im = cj ? xi*wr - xr*wi : xr*wi + xi*wr;
        r.yr = ref_cvt(re);
        r.yi = ref_cvt(im);
        return r;
    endfunction

    task automatic send(input logic [N-1:0] a, b, c, d, input logic cj, input exp_t e);
        int n;
        n = 0;
        while (dif.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(dif.in_ready), 32'd1);
        sb.push_back(e);
        dif.xr       = a;
        dif.xi       = b;
        dif.wr       = c;
        dif.wi       = d;
        dif.conj     = cj;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        dif.xr       = 16'($urandom);
        dif.xi       = 16'($urandom);
        dif.wr       = 16'($urandom);
        dif.wi       = 16'($urandom);
        dif.conj     = 1'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (dif.out_valid !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_timeout", 32'(dif.out_valid), 32'd1);
    endtask

    // Scoreboard: compare once per result, on the first cycle Out_Valid is seen.
    logic prev_ov = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (dif.out_valid === 1'b1 && !prev_ov) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("yr", 32'(dif.yr), 32'(mon_e.yr));
                check("yi", 32'(dif.yi), 32'(mon_e.yi));
            end
        end
        prev_ov <= dif.out_valid;
    end

    initial begin
        int           ld_at [4];
        int           ld_n;
        int           ov_cyc;
        int           cyc;
        logic         stable;
        logic [N-1:0] hold_yr, hold_yi;
        logic [N-1:0] ra, rb, rc, rd;
        logic         rcj;

        rst           = 1'b1;
        spur          = 1'b0;
        dif.in_valid  = 1'b0;
        dif.conj      = 1'b0;
        dif.xr        = '0;
        dif.xi        = '0;
        dif.wr        = '0;
        dif.wi        = '0;
        dif.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready",  32'(dif.in_ready),  32'd0);
        check("rst_mul_ld",    32'(dif.mul_ld),    32'd0);
        check("rst_mul_m",     32'(dif.mul_m),     32'd0);
        check("rst_mul_r",     32'(dif.mul_r),     32'd0);
        check("rst_out_valid", 32'(dif.out_valid), 32'd0);
        check("rst_yr",        32'(dif.yr),        32'd0);
        check("rst_yi",        32'(dif.yi),        32'd0);

        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

        // Case 1: timing of Ld pulses and result.
        send(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, '{yr: 16'h4000, yi: 16'h0000});
        ld_n   = 0;
        ov_cyc = 0;
        for (int c = 1; c <= 80 && ov_cyc == 0; c++) begin
            @(negedge clk);
            if (dif.mul_ld === 1'b1) begin
                if (ld_n < 4) ld_at[ld_n] = c;
                ld_n++;
            end
            if (dif.out_valid === 1'b1) ov_cyc = c;
        end
        check("ld_count", 32'(ld_n), 32'd4);
        check("ld_cyc0", 32'(ld_at[0]), 32'd1);
        check("ld_cyc1", 32'(ld_at[1]), 32'd11);
        check("ld_cyc2", 32'(ld_at[2]), 32'd21);
        check("ld_cyc3", 32'(ld_at[3]), 32'd31);
        check("out_valid_cycle", 32'(ov_cyc), 32'd41);

        // Saturation and conjugate corners.
        send(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, '{yr: 16'h7FFF, yi: 16'h0001});
        send(16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, '{yr: 16'h8000, yi: 16'hFFFF});
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1, '{yr: 16'h7FFF, yi: 16'h0000});
        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, '{yr: 16'h0000, yi: 16'h7FFF});

        // Random operands against the reference model.
        for (int i = 0; i < 6; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 16'($urandom);
            rd  = 16'($urandom);
            rcj = 1'($urandom);
            send(ra, rb, rc, rd, rcj, ref_y(ra, rb, rc, rd, rcj));
        end

        // Backpressure with spurious Mul_Valid during OUT.
        wait_out(cyc);
        @(negedge clk);
        dif.out_ready = 1'b0;
        send(16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 1'b0, '{yr: 16'h7FFF, yi: 16'h0001});
        wait_out(cyc);
        hold_yr = dif.yr;
        hold_yi = dif.yi;
        stable  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            spur = (c == 5);
            @(negedge clk);
            if (dif.yr !== hold_yr || dif.yi !== hold_yi ||
                dif.in_ready !== 1'b0 || dif.out_valid !== 1'b1) stable = 1'b0;
        end
        spur = 1'b0;
        check("out_hold_stable", 32'(stable), 32'd1);
        check("out_hold_yr", 32'(dif.yr), 32'h7FFF);
        dif.out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", 32'(dif.out_valid), 32'd0);
        check("release_in_ready",  32'(dif.in_ready),  32'd1);

        // Spurious Mul_Valid in IDLE.
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("idle_spur_in_ready",  32'(dif.in_ready),  32'd1);
        check("idle_spur_out_valid", 32'(dif.out_valid), 32'd0);
        check("idle_spur_mul_ld",    32'(dif.mul_ld),    32'd0);
        check("idle_spur_yr",        32'(dif.yr),        32'(hold_yr));
        check("idle_spur_yi",        32'(dif.yi),        32'(hold_yi));

        // Async reset in WAIT with k=2, then a clean transaction.
        send(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, '{yr: 16'h4000, yi: 16'h0000});
        for (int c = 1; c <= 25; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_mul_ld",    32'(dif.mul_ld),    32'd0);
        check("abort_out_valid", 32'(dif.out_valid), 32'd0);
        check("abort_in_ready",  32'(dif.in_ready),  32'd0);
        check("abort_yr",        32'(dif.yr),        32'd0);
        check("abort_yi",        32'(dif.yi),        32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, '{yr: 16'h4000, yi: 16'h0000});
        wait_out(cyc);
        check("post_abort_latency", 32'(cyc), 32'd41);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
